// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU ops
// behind a two-entry skid buffer with registered outputs and in_ready.
package alu_issue_pkg;
  localparam int ALU_OP_LENGTH = 4;

  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLL  = 4'd2;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLT  = 4'd3;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLTU = 4'd4;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_XOR  = 4'd5;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRL  = 4'd6;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRA  = 4'd7;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_OR   = 4'd8;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_AND  = 4'd9;

  typedef struct packed {
    logic [ALU_OP_LENGTH-1:0] op;
    logic [31:0]              left;
    logic [31:0]              right;
    logic [4:0]               rd;
    logic                     rd_we;
    logic                     illegal;
  } iss_t;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              rs1_data,
  input  logic [31:0]              rs2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_OP_LENGTH-1:0] alu_opcode,
  output logic [31:0]              alu_left,
  output logic [31:0]              alu_right,
  output logic [4:0]               rd,
  output logic                     rd_we,
  output logic                     illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] sh_r;
  logic [31:0] sh_i;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign sh_r  = {27'b0, rs2_data[4:0]};
  assign sh_i  = {27'b0, in_instr[24:20]};

  iss_t                     dec;
  logic [ALU_OP_LENGTH-1:0] op;
  logic [31:0]              left;
  logic [31:0]              right;
  logic                     legal;

  always_comb begin
    op    = ALU_OP_ADD;
    left  = '0;
    right = '0;
    legal = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        left  = rs1_data;
        right = rs2_data;
        legal = f7 == 7'h00;
        unique case (f3)
          3'd0: if (f7 == 7'h20) begin
            op    = ALU_OP_SUB;
            legal = 1'b1;
          end
          3'd1: begin
            op    = ALU_OP_SLL;
            right = sh_r;
          end
          3'd2: op = ALU_OP_SLT;
          3'd3: op = ALU_OP_SLTU;
          3'd4: op = ALU_OP_XOR;
          3'd5: begin
            op    = ALU_OP_SRL;
            right = sh_r;
          end
          3'd6: op = ALU_OP_OR;
          3'd7: op = ALU_OP_AND;
        endcase
      end
      opc == OPC_OPIMM: begin
        left  = rs1_data;
        right = imm_i;
        legal = 1'b1;
        unique case (f3)
          3'd0: op = ALU_OP_ADD;
          3'd1: begin
            op    = ALU_OP_SLL;
            right = sh_i;
            legal = f7 == 7'h00;
          end
          3'd2: op = ALU_OP_SLT;
          3'd3: op = ALU_OP_SLTU;
          3'd4: op = ALU_OP_XOR;
          3'd5: begin
            op    = ALU_OP_SRL;
            right = sh_i;
            legal = f7 == 7'h00;
          end
          3'd6: op = ALU_OP_OR;
          3'd7: op = ALU_OP_AND;
        endcase
      end
      opc == OPC_LUI: begin
        right = imm_u;
        legal = 1'b1;
      end
      opc == OPC_AUIPC: begin
        left  = in_pc;
        right = imm_u;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal ops still flow through as a harmless ADD 0,0 with no write-back.
  always_comb begin
    dec         = '0;
    dec.op      = legal ? op : ALU_OP_ADD;
    dec.left    = legal ? left : 32'd0;
    dec.right   = legal ? right : 32'd0;
    dec.rd      = in_instr[11:7];
    dec.rd_we   = legal && (in_instr[11:7] != 5'd0);
    dec.illegal = !legal;
  end

  iss_t main_q;
  iss_t skid_q;
  logic main_valid;
  logic skid_valid;
  logic accept;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      main_q.op  <= ALU_OP_ADD;
      skid_q     <= '0;
      skid_q.op  <= ALU_OP_ADD;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign alu_opcode = main_q.op;
  assign alu_left   = main_q.left;
  assign alu_right  = main_q.right;
  assign rd         = main_q.rd;
  assign rd_we      = main_q.rd_we;
  assign illegal    = main_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue stage between the register-file read and the ALU: accepts one 32-bit RV32I instruction per cycle with its source operands over a valid/ready handshake. It decodes OP, OP-IMM, LUI and AUIPC into an ALU opcode plus left/right operands, and presents them to the ALU on a second valid/ready handshake. Full throughput is one instruction per cycle with fully registered outputs and a registered `in_ready`, implemented as a two-entry skid buffer.

## Interface
- `ALU_OP_LENGTH`, from `rtl/parameters.vh`: width of the ALU opcode. Opcode values are the `ALU_OP_*` codes in that header.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `flush` in 1: synchronous; drops all buffered instructions.
- `in_valid` in 1: instruction, `in_pc`, `rs1_data` and `rs2_data` are valid.
- `in_ready` out 1: stage can accept an instruction. Registered.
- `in_instr` in 32: RV32I instruction word.
- `in_pc` in 32: PC of the instruction (used by AUIPC).
- `rs1_data` in 32: register-file value of rs1.
- `rs2_data` in 32: register-file value of rs2.
- `out_valid` out 1: decoded operation valid.
- `out_ready` in 1: ALU side consumes the operation.
- `alu_opcode` out `ALU_OP_LENGTH`: ALU operation.
- `alu_left` out 32: left operand.
- `alu_right` out 32: right operand.
- `rd` out 5: destination register index.
- `rd_we` out 1: write-back enable.
- `illegal` out 1: instruction not executable by the ALU.

## Operation
- Handshakes:
  - Input transfer when `in_valid & in_ready` at a rising edge.
  - Output transfer when `out_valid & out_ready`.
  - `out_valid` and all output data stay stable until transferred.
- Decode by `in_instr[6:0]`:
  - OP (0110011), left = rs1_data:
    - funct3/funct7 map to ADD, SUB (funct7 0x20, funct3 0), SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - right = rs2_data, except SLL/SRL where right = {27'b0, rs2_data[4:0]}.
  - OP-IMM (0010011), left = rs1_data:
    - ADDI, SLTI, SLTIU, XORI, ORI, ANDI use right = sign-extended `instr[31:20]`.
    - SLLI (funct7 0) and SRLI (funct7 0) use right = {27'b0, `instr[24:20]`}.
  - LUI (0110111): ADD, left = 0, right = {`instr[31:12]`, 12'b0}.
  - AUIPC (0010111): ADD, left = in_pc, right = {`instr[31:12]`, 12'b0}.
- Illegal cases:
  - Covered: SRA/SRAI, any other funct7 on OP, any other opcode.
  - Output: `illegal`=1, `rd_we`=0, `alu_opcode`=ALU_OP_ADD, `alu_left`=`alu_right`=0.
  - The instruction is still transferred; it is never dropped silently.
- `rd` = `instr[11:7]`. `rd_we` = legal & (rd != 0).
- Skid buffer:
  - Main register drives the outputs.
  - Skid register captures an accepted input when the main register is valid and `out_ready`=0.
  - `in_ready` = !skid_valid, registered.
  - When the main register empties, the skid entry moves into it ahead of any new input, so order is preserved.
- `flush`: at the edge, main_valid = skid_valid = 0 and no input is accepted. `in_ready` is 1 the next cycle. `flush` has priority over `out_ready` and `in_valid`.

## Timing
- Reset: `out_valid`=0, `in_ready`=1 from the cycle after reset. `alu_opcode`=ALU_OP_ADD, `alu_left`=`alu_right`=0, `rd`=0, `rd_we`=0, `illegal`=0. Skid buffer empty.
- Reset mid-operation discards both entries; nothing is transferred afterwards.
- Latency: an input accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Throughput: 1 per cycle while `out_ready`=1.
- Stalls:
  - One stall cycle with a new input fills the skid entry; `in_ready` drops after that edge.
  - With both entries full, `in_ready`=0 until the output transfers.
  - Simultaneous output transfer and input accept with the skid empty: main register reloads in the same edge, no bubble.
- Decode is performed on input acceptance. Operands are captured at acceptance and never re-sampled.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle ALU_OP_ADD, left 5, right 7, rd 3, rd_we 1.
- ADDI x1,x0,-1 (0xFFF00093) -> right 0xFFFFFFFF. SLLI x5,x5,3 (0x00329293) -> ALU_OP_SLL, right 3. SLL with rs2=0x25 -> right 5.
- SRAI (0x4032D293) -> illegal=1, rd_we=0, ALU_OP_ADD, operands 0. LUI x1,0x12345 (0x123450B7) -> left 0, right 0x12345000. AUIPC with pc=0x100 -> left 0x100.
- Back-to-back 4 instructions, `out_ready` low for 2 cycles after the first -> `in_ready` falls once skid is full. All 4 emerge in order, none lost or duplicated.
- `flush` asserted with both entries full plus `in_valid`=1 -> `out_valid`=0 next cycle, input not accepted, `in_ready`=1.
- `rst_n` low for 1 cycle mid-stream -> all outputs at reset values, `out_valid` stays 0 until a new input is accepted.
